// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive-side buffer.
package uart_pkg;

  localparam int UART_WIDTH = 8;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// WIDTH x DEPTH register array: synchronous write, combinational read, no reset.
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffers words from the UART receiver and hands them to a valid/ready consumer.
// Back-pressures the receiver through rx_can_receive; drops while full set a sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH       = UART_WIDTH,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     rx_ready,
  input  logic [WIDTH-1:0]         rx_data,
  output logic                     rx_can_receive,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef logic [CW-1:0] count_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  count_t        occ;
  logic          push, pop, drop;

  assign empty          = (occ == '0);
  assign full           = (occ == count_t'(DEPTH));
  assign almost_full    = (occ >= count_t'(AFULL_LEVEL));
  assign count          = occ;
  assign out_valid      = !empty;
  assign rx_can_receive = !full;

  // A pop frees the head slot in the same edge, so a full buffer can still accept.
  assign pop  = out_valid && out_ready;
  assign push = rx_ready && (!full || pop);
  assign drop = rx_ready && full && !pop;

  uart_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
      if (pop)  rd_ptr <= PW'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
      if (push && !pop)      occ <= occ + count_t'(1);
      else if (pop && !push) occ <= occ - count_t'(1);
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios then random traffic against a queue model.
module tb_uart_rx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             rx_ready = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_can_receive;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [4:0]       count;
  logic             empty, full, almost_full, overflow;
  logic             clear_overflow = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  bit               ovf_m = 1'b0;

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_can_receive (rx_can_receive),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Monitor + reference model: sampled mid-cycle, before the edge that acts on the inputs.
  always @(negedge clock) begin
    if (!resetn) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      int  n;
      bit  pop_m, push_m, drop_m;
      n = exp_q.size();
      chk("mon_count", int'(count), n);
      chk("mon_valid", int'(out_valid), int'(n > 0));
      chk("mon_flags", {full, empty, almost_full, rx_can_receive},
          {n == DEPTH, n == 0, n >= AFULL, n != DEPTH});
      chk("mon_overflow", int'(overflow), int'(ovf_m));
      pop_m  = (n > 0) && out_ready;
      push_m = rx_ready && ((n != DEPTH) || pop_m);
      drop_m = rx_ready && (n == DEPTH) && !pop_m;
      if (out_valid && out_ready) begin
        if (n > 0) chk("mon_data", int'(out_data), int'(exp_q.pop_front()));
        else       chk("mon_pop_when_model_empty", 1, 0);
      end
      if (push_m) exp_q.push_back(rx_data);
      if (drop_m) ovf_m = 1'b1;
      else if (clear_overflow) ovf_m = 1'b0;
    end
  end

  task automatic step(input logic rr, input logic [WIDTH-1:0] d, input logic ordy, input logic clr);
    rx_ready = rr; rx_data = d; out_ready = ordy; clear_overflow = clr;
    @(posedge clock); #1;
    rx_ready = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_afull"}, int'(almost_full), 0);
    chk({tag, "_can_rx"}, int'(rx_can_receive), 1);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int max_cnt;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    resetn = 1'b1;
    @(posedge clock); #1;

    // single word
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 'hA5);
    chk("t1_count", int'(count), 1);
    chk("t1_empty", int'(empty), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_count_after_pop", int'(count), 0);
    chk("t1_empty_after_pop", int'(empty), 1);

    // fill to full
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("t2_afull", int'(almost_full), int'(i + 1 >= AFULL));
    end
    chk("t2_count", int'(count), DEPTH);
    chk("t2_full", int'(full), 1);
    chk("t2_can_rx", int'(rx_can_receive), 0);

    // drop while full, sticky overflow, then clear
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("t3_count", int'(count), DEPTH);
    chk("t3_ovf", int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_ovf_sticky", int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_ovf_clear", int'(overflow), 0);

    // simultaneous push and pop while full
    chk("t4_head", int'(out_data), 'h00);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t4_count", int'(count), DEPTH);
    chk("t4_ovf", int'(overflow), 0);
    chk("t4_new_head", int'(out_data), 'h01);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_drained", int'(empty), 1);

    // streaming across pointer wrap
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_max_count_le_depth", int'(max_cnt <= DEPTH), 1);
    chk("t5_drained", int'(count), 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    chk("t6_count_before", int'(count), 5);
    #3 resetn = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("t6_first_word", int'(out_data), 'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rand_drained", int'(count), 0);

    @(posedge clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
